// File: rtl/shift_pkg.sv
// Shared types and sizing helpers for the parametrised PUF challenge shift register.
package shift_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        SHL  = 2'b01,
        SHR  = 2'b10,
        LOAD = 2'b11
    } shift_mode_t;

    // Bits needed to hold a fill count ranging over 0..depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/shift_lane.sv
// One DEPTH-bit shift lane: stage register plus the bit most recently shifted out.
module shift_lane #(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shl,
    input  logic             shr,
    input  logic             load,
    input  logic             sin,
    input  logic [DEPTH-1:0] load_data,
    output logic [DEPTH-1:0] stages,
    output logic             sout
);

    logic [DEPTH-1:0] stage_p0;
    logic             sout_p0;
    logic [DEPTH-1:0] sin_lsb;
    logic [DEPTH-1:0] sin_msb;
    logic [DEPTH-1:0] shl_nxt;
    logic [DEPTH-1:0] shr_nxt;

    // Shift by whole-vector operations so DEPTH=1 needs no special case.
    assign sin_lsb = DEPTH'(sin);
    assign sin_msb = sin_lsb << (DEPTH - 1);
    assign shl_nxt = (stage_p0 << 1) | sin_lsb;
    assign shr_nxt = (stage_p0 >> 1) | sin_msb;

    // Stage p0: lane registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_p0 <= '0;
            sout_p0  <= 1'b0;
        end else if (clr) begin
            stage_p0 <= '0;
            sout_p0  <= 1'b0;
        end else if (load) begin
            stage_p0 <= load_data;
        end else if (shl) begin
            stage_p0 <= shl_nxt;
            sout_p0  <= stage_p0[DEPTH-1];
        end else if (shr) begin
            stage_p0 <= shr_nxt;
            sout_p0  <= stage_p0[0];
        end
    end

    assign stages = stage_p0;
    assign sout   = sout_p0;

endmodule

// File: rtl/shift_register_param.sv
// Multi-lane PUF challenge shift register with shared saturating fill counter and done pulse.
module shift_register_param #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic                       clr,
    input  logic [WIDTH-1:0]           sin,
    input  logic [WIDTH*DEPTH-1:0]     load_data,
    output logic [WIDTH*DEPTH-1:0]     pout,
    output logic [WIDTH-1:0]           sout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       done
);
    import shift_pkg::*;

    localparam int            CW      = cnt_w(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == DEPTH_C) ? c : c + CW'(1);
    endfunction

    shift_mode_t   mode_e;
    logic          act;
    logic          do_shl;
    logic          do_shr;
    logic          do_load;
    logic          do_shift;
    logic [CW-1:0] count_p0;
    logic          done_p0;

    // clr wins over en and mode; en gates every non-clear operation.
    assign mode_e   = shift_mode_t'(mode);
    assign act      = en & ~clr;
    assign do_shl   = act && (mode_e == SHL);
    assign do_shr   = act && (mode_e == SHR);
    assign do_load  = act && (mode_e == LOAD);
    assign do_shift = do_shl | do_shr;

    for (genvar l = 0; l < WIDTH; l++) begin : g_lane
        shift_lane #(
            .DEPTH(DEPTH)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .clr      (clr),
            .shl      (do_shl),
            .shr      (do_shr),
            .load     (do_load),
            .sin      (sin[l]),
            .load_data(load_data[l*DEPTH +: DEPTH]),
            .stages   (pout[l*DEPTH +: DEPTH]),
            .sout     (sout[l])
        );
    end

    // Stage p0: shared fill counter and done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_p0 <= '0;
            done_p0  <= 1'b0;
        end else if (clr) begin
            count_p0 <= '0;
            done_p0  <= 1'b0;
        end else begin
            done_p0 <= do_shift && (count_p0 == LAST_C);
            if (do_load) begin
                count_p0 <= DEPTH_C;
            end else if (do_shift) begin
                count_p0 <= sat_inc(count_p0);
            end
        end
    end

    assign count = count_p0;
    assign full  = (count_p0 == DEPTH_C);
    assign done  = done_p0;

endmodule

// File: tb/tb_shift_register_param.sv
// Scoreboard bench: three configurations (1x8, 4x4, 1x1) driven in lockstep against an integer lane model.
module tb_shift_register_param;
    import shift_pkg::*;

    logic        clk = 1'b0;
    logic        rst, en, clr;
    logic [1:0]  mode;
    logic [3:0]  sin;
    logic [31:0] load_data;

    logic [7:0]  p8;  logic       s8;  logic [3:0] c8;  logic f8, d8;
    logic [15:0] p4;  logic [3:0] s4;  logic [2:0] c4;  logic f4, d4;
    logic        p1;  logic       s1;  logic [0:0] c1;  logic f1, d1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pout;
        logic [31:0] sout;
        int          cnt;
        logic        full;
        logic        done;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t sb2[$];

    // Model state: each lane held as an integer, stage s = bit s.
    int unsigned lane_v[3][4];
    int unsigned sout_v[3][4];
    int          cnt_m[3];
    bit          done_m[3];

    always #5 clk = ~clk;

    shift_register_param #(.WIDTH(1), .DEPTH(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .clr(clr), .sin(sin[0:0]),
        .load_data(load_data[7:0]), .pout(p8), .sout(s8), .count(c8), .full(f8), .done(d8));

    shift_register_param #(.WIDTH(4), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .clr(clr), .sin(sin),
        .load_data(load_data[15:0]), .pout(p4), .sout(s4), .count(c4), .full(f4), .done(d4));

    shift_register_param #(.WIDTH(1), .DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .clr(clr), .sin(sin[0:0]),
        .load_data(load_data[0:0]), .pout(p1), .sout(s1), .count(c1), .full(f1), .done(d1));

    function automatic int w_of(int k);
        return (k == 1) ? 4 : 1;
    endfunction

    function automatic int d_of(int k);
        return (k == 0) ? 8 : ((k == 1) ? 4 : 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int l = 0; l < 4; l++) begin
                lane_v[k][l] = 0;
                sout_v[k][l] = 0;
            end
            cnt_m[k]  = 0;
            done_m[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input bit e, input logic [1:0] m, input bit c,
                              input logic [3:0] s, input logic [31:0] ld);
        int          w    = w_of(k);
        int          d    = d_of(k);
        int unsigned mask = (32'd1 << d) - 1;
        if (c) begin
            for (int l = 0; l < 4; l++) begin
                lane_v[k][l] = 0;
                sout_v[k][l] = 0;
            end
            cnt_m[k]  = 0;
            done_m[k] = 1'b0;
        end else if (!e || m == HOLD) begin
            done_m[k] = 1'b0;
        end else if (m == LOAD) begin
            for (int l = 0; l < w; l++) lane_v[k][l] = (ld >> (l * d)) & mask;
            cnt_m[k]  = d;
            done_m[k] = 1'b0;
        end else begin
            for (int l = 0; l < w; l++) begin
                int unsigned v  = lane_v[k][l];
                int unsigned si = int'(s[l]);
                if (m == SHL) begin
                    sout_v[k][l] = (v >> (d - 1)) & 1;
                    lane_v[k][l] = ((v << 1) | si) & mask;
                end else begin
                    sout_v[k][l] = v & 1;
                    lane_v[k][l] = (v >> 1) | (si << (d - 1));
                end
            end
            done_m[k] = (cnt_m[k] == d - 1);
            if (cnt_m[k] < d) cnt_m[k]++;
        end
    endtask

    function automatic exp_t model_exp(int k);
        exp_t e;
        int   d = d_of(k);
        e.pout = 0;
        e.sout = 0;
        for (int l = 0; l < w_of(k); l++) begin
            e.pout |= lane_v[k][l] << (l * d);
            e.sout |= sout_v[k][l] << l;
        end
        e.cnt  = cnt_m[k];
        e.full = (cnt_m[k] == d);
        e.done = done_m[k];
        return e;
    endfunction

    function automatic exp_t act_of(int k);
        exp_t a;
        case (k)
            0: begin a.pout = 32'(p8); a.sout = 32'(s8); a.cnt = int'(c8); a.full = f8; a.done = d8; end
            1: begin a.pout = 32'(p4); a.sout = 32'(s4); a.cnt = int'(c4); a.full = f4; a.done = d4; end
            default: begin a.pout = 32'(p1); a.sout = 32'(s1); a.cnt = int'(c1); a.full = f1; a.done = d1; end
        endcase
        return a;
    endfunction

    task automatic cmp(input int k, input exp_t a, input exp_t e, input string tag);
        chk($sformatf("%s.dut%0d.pout", tag, k), a.pout, e.pout);
        chk($sformatf("%s.dut%0d.sout", tag, k), a.sout, e.sout);
        chk($sformatf("%s.dut%0d.count", tag, k), 32'(a.cnt), 32'(e.cnt));
        chk($sformatf("%s.dut%0d.full", tag, k), 32'(a.full), 32'(e.full));
        chk($sformatf("%s.dut%0d.done", tag, k), 32'(a.done), 32'(e.done));
    endtask

    task automatic do_op(input bit e, input logic [1:0] m, input bit c,
                         input logic [3:0] s, input logic [31:0] ld);
        @(negedge clk);
        en = e; mode = m; clr = c; sin = s; load_data = ld;
        for (int k = 0; k < 3; k++) model_step(k, e, m, c, s, ld);
        sb0.push_back(model_exp(0));
        sb1.push_back(model_exp(1));
        sb2.push_back(model_exp(2));
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic async_reset(input string tag);
        settle();
        rst = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) cmp(k, act_of(k), model_exp(k), tag);
        #1 rst = 1'b0;
    endtask

    // Monitor: one result per clock edge, compared against the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (sb0.size() > 0) cmp(0, act_of(0), sb0.pop_front(), "sb");
        if (sb1.size() > 0) cmp(1, act_of(1), sb1.pop_front(), "sb");
        if (sb2.size() > 0) cmp(2, act_of(2), sb2.pop_front(), "sb");
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fill_bits;
        rst = 1'b1; en = 1'b0; mode = HOLD; clr = 1'b0; sin = '0; load_data = '0;
        model_reset();
        #12;
        for (int k = 0; k < 3; k++) cmp(k, act_of(k), model_exp(k), "reset");
        rst = 1'b0;

        // Async reset while the register holds 0xA5.
        do_op(1, LOAD, 0, 4'h0, 32'h0000_A5A5);
        settle();
        chk("preload.p8", 32'(p8), 32'hA5);
        async_reset("async_rst");

        // SHL fill, stage 0 receives the newest bit.
        fill_bits = 8'b1011_0010;
        do_op(1, HOLD, 1, 4'h0, 32'h0);
        for (int i = 0; i < 8; i++) do_op(1, SHL, 0, {4{fill_bits[i]}}, 32'h0);
        settle();
        chk("fill.pout", 32'(p8), 32'h4D);
        chk("fill.count", 32'(c8), 32'd8);
        chk("fill.full", 32'(f8), 32'd1);
        chk("fill.done", 32'(d8), 32'd1);
        do_op(1, SHL, 0, 4'hF, 32'h0);
        settle();
        chk("ninth.pout", 32'(p8), 32'h9B);
        chk("ninth.sout", 32'(s8), 32'd0);
        chk("ninth.done", 32'(d8), 32'd0);

        // LOAD then SHR.
        do_op(1, LOAD, 0, 4'h0, 32'h0000_8181);
        settle();
        chk("load.count", 32'(c8), 32'd8);
        chk("load.done", 32'(d8), 32'd0);
        do_op(1, SHR, 0, 4'h0, 32'h0);
        settle();
        chk("shr.pout", 32'(p8), 32'h40);
        chk("shr.sout", 32'(s8), 32'd1);

        // clr beats LOAD; en=0 freezes everything.
        do_op(1, LOAD, 1, 4'hF, 32'hFFFF_FFFF);
        settle();
        chk("clr.pout", 32'(p8), 32'h0);
        chk("clr.count", 32'(c8), 32'd0);
        do_op(1, LOAD, 0, 4'h0, 32'h0000_3C3C);
        for (int i = 0; i < 5; i++) do_op(0, SHL, 0, 4'hF, 32'h0);
        settle();
        chk("hold.pout", 32'(p8), 32'h3C);

        // Multi-lane lockstep fill.
        do_op(1, HOLD, 1, 4'h0, 32'h0);
        for (int i = 0; i < 4; i++) do_op(1, SHL, 0, 4'b1010, 32'h0);
        settle();
        chk("lanes.pout", 32'(p4), 32'hF0F0);
        chk("lanes.count", 32'(c4), 32'd4);

        // DEPTH=1: first shift fills and pulses done.
        do_op(1, HOLD, 1, 4'h0, 32'h0);
        do_op(1, SHL, 0, 4'b0001, 32'h0);
        settle();
        chk("d1.pout", 32'(p1), 32'd1);
        chk("d1.count", 32'(c1), 32'd1);
        chk("d1.done", 32'(d1), 32'd1);
        do_op(1, SHL, 0, 4'b0001, 32'h0);
        settle();
        chk("d1.sat_done", 32'(d1), 32'd0);

        // Randomised traffic, shifts favoured so the counter saturates often.
        for (int i = 0; i < 400; i++) begin
            bit          e = ($urandom_range(0, 9) != 0);
            bit          c = ($urandom_range(0, 29) == 0);
            int          r = $urandom_range(0, 9);
            logic [1:0]  m = (r < 4) ? SHL : (r < 8) ? SHR : (r == 8) ? LOAD : HOLD;
            logic [3:0]  s = 4'($urandom);
            logic [31:0] ld = $urandom;
            do_op(e, m, c, s, ld);
            if (i % 97 == 50) async_reset("rand_rst");
        end

        do_op(1, HOLD, 0, 4'h0, 32'h0);
        settle();
        settle();
        chk("drain", 32'(sb0.size() + sb1.size() + sb2.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
